shift_pla_inverse: RTL and testbench

//  Iterative shift/add piecewise-linear approximation of atanh(y), the inverse of the shift-based tanh PLA.

---
 rtl/shift_pla_inverse.sv | 147 ++++++++++++++
 tb/tb_shift_pla_inverse.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/shift_pla_inverse.sv
// Multiplier-free piecewise-linear atanh(y) approximation, the inverse of the shift-based tanh PLA.
// One operand at a time: leading-zero pair scan selects the segment, then a 3-term shift-add applies the slope.
module shift_pla_inverse #(
  parameter int unsigned W_IN  = 9,
  parameter int unsigned W_OUT = 12,
  parameter int unsigned OUT_I = 4,
  parameter int unsigned OUT_F = 8,
  parameter int unsigned K_MAX = 3
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W_IN-1:0]  y_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W_OUT-1:0] x_out
);

  localparam int unsigned Y_F   = W_IN - 1;
  localparam int unsigned ACC_W = OUT_F + 1;
  localparam int unsigned MAG_W = OUT_I + OUT_F;
  localparam int unsigned KW    = $clog2(K_MAX + 1);
  localparam logic [KW-1:0]   K_LAST = KW'(K_MAX - 1);
  localparam logic [W_IN-1:0] ONE    = W_IN'(1) << Y_F;

  typedef enum logic [2:0] {IDLE, SCAN, ACC, OUTP, DONE} state_t;

  state_t             state_q, state_d;
  logic               sign_q, sign_d;
  logic               sat_q, sat_d;
  logic [Y_F-1:0]     dsh_q, dsh_d;
  logic [KW-1:0]      k_q, k_d;
  logic [Y_F-1:0]     r_q, r_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [1:0]         ph_q, ph_d;
  logic [W_OUT-1:0]   x_q, x_d;
  logic               ov_q, ov_d;

  logic [W_IN-1:0]    m_abs;
  logic [Y_F-1:0]     d_in;
  logic [Y_F-1:0]     r_now;
  logic [ACC_W-1:0]   r_ext;
  logic [MAG_W-1:0]   mag;

  // m spans Y_F+1 bits so that y = -1.0 yields exactly ONE
  assign m_abs = y_in[W_IN-1] ? (~y_in + W_IN'(1)) : y_in;
  assign d_in  = Y_F'(ONE - m_abs);
  // dsh_q already holds d << 2k, so 1 - (d << 2k) is its modular negation
  assign r_now = (~dsh_q) + Y_F'(1);
  assign r_ext = ACC_W'(r_q) << (OUT_F - Y_F);
  assign mag   = sat_q ? (MAG_W'(K_MAX) << OUT_F)
                       : ((MAG_W'(k_q) << OUT_F) + MAG_W'(acc_q));

  assign in_ready  = (state_q == IDLE);
  assign out_valid = ov_q;
  assign x_out     = x_q;

  always_comb begin
    state_d = state_q;
    sign_d  = sign_q;
    sat_d   = sat_q;
    dsh_d   = dsh_q;
    k_d     = k_q;
    r_d     = r_q;
    acc_d   = acc_q;
    ph_d    = ph_q;
    x_d     = x_q;
    ov_d    = ov_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          sign_d = y_in[W_IN-1];
          dsh_d  = d_in;
          k_d    = '0;
          acc_d  = '0;
          sat_d  = (m_abs == ONE);
          if ((m_abs == '0) || (m_abs == ONE)) state_d = OUTP;
          else                                 state_d = SCAN;
        end
      end
      SCAN: begin
        if (dsh_q[Y_F-1 -: 2] != 2'b00) begin
          r_d     = r_now;
          ph_d    = 2'd0;
          state_d = ACC;
        end else if (k_q == K_LAST) begin
          sat_d   = 1'b1;
          state_d = OUTP;
        end else begin
          k_d   = k_q + KW'(1);
          dsh_d = dsh_q << 2;
        end
      end
      ACC: begin
        ph_d = ph_q + 2'd1;
        case (ph_q)
          2'd0:    acc_d = r_ext;
          2'd1:    acc_d = acc_q + (r_ext >> 2);
          default: begin
            acc_d   = acc_q + (r_ext >> 4);
            state_d = OUTP;
          end
        endcase
      end
      OUTP: begin
        x_d     = sign_q ? W_OUT'(-mag) : W_OUT'(mag);
        ov_d    = 1'b1;
        state_d = DONE;
      end
      DONE: begin
        if (out_ready) begin
          ov_d    = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      sign_q  <= 1'b0;
      sat_q   <= 1'b0;
      dsh_q   <= '0;
      k_q     <= '0;
      r_q     <= '0;
      acc_q   <= '0;
      ph_q    <= 2'd0;
      x_q     <= '0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      sign_q  <= sign_d;
      sat_q   <= sat_d;
      dsh_q   <= dsh_d;
      k_q     <= k_d;
      r_q     <= r_d;
      acc_q   <= acc_d;
      ph_q    <= ph_d;
      x_q     <= x_d;
      ov_q    <= ov_d;
    end
  end

endmodule

// File: tb/tb_shift_pla_inverse.sv
// Scoreboard bench for shift_pla_inverse: directed values, back-pressure, mid-operation reset, random operands.
module tb_shift_pla_inverse;

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [8:0]  y_in = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [11:0] x_out;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [8:0]  y;
    logic [11:0] x;
    int          lat;
  } exp_t;

  exp_t sb[$];

  shift_pla_inverse #(.W_IN(9), .W_OUT(12), .OUT_I(4), .OUT_F(8), .K_MAX(3)) dut (
    .clock     (clock),
    .resetn    (resetn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .y_in      (y_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .x_out     (x_out)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: segment k from the first nonzero bit pair of d = 1-|y|, slope applied as r + r/4 + r/16
  function automatic void model(input logic [8:0] y, output logic [11:0] x, output int lat);
    int yi, m, d, r, acc, mag;
    bit found;
    yi  = y[8] ? int'(y) - 512 : int'(y);
    m   = (yi < 0) ? -yi : yi;
    mag = 0;
    lat = 1;
    if (m == 256) mag = 3 * 256;
    else if (m != 0) begin
      d = 256 - m;
      found = 0;
      for (int k = 0; k < 3 && !found; k++) begin
        if (((d >> (6 - 2 * k)) & 3) != 0) begin
          r     = 256 - (d << (2 * k));
          acc   = r + (r >> 2) + (r >> 4);
          mag   = k * 256 + acc;
          lat   = k + 1 + 3 + 1;
          found = 1;
        end
      end
      if (!found) begin
        mag = 3 * 256;
        lat = 3 + 1;
      end
    end
    x = (yi < 0) ? 12'(-mag) : 12'(mag);
  endfunction

  task automatic applyStimulus(input logic [8:0] y, input logic [11:0] x, input int lat);
    exp_t e;
    @(negedge clock);
    checkOutput("in_ready before accept", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    y_in     = y;
    e.y = y; e.x = x; e.lat = lat;
    sb.push_back(e);
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    y_in     = 9'($urandom);
  endtask

  task automatic collectResult(input int hold);
    int   lat;
    exp_t e;
    lat = 0;
    while (!out_valid && lat < 30) begin
      @(posedge clock);
      #1;
      lat++;
    end
    if (sb.size() == 0) begin
      checkOutput("scoreboard empty", 32'(sb.size()), 32'd1);
      return;
    end
    e = sb.pop_front();
    checkOutput("out_valid", 32'(out_valid), 32'd1);
    checkOutput($sformatf("latency y=0x%03h", e.y), 32'(lat), 32'(e.lat));
    checkOutput($sformatf("x_out y=0x%03h", e.y), 32'(x_out), 32'(e.x));
    checkOutput("in_ready busy", 32'(in_ready), 32'd0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clock);
      in_valid = 1'b1;
      y_in     = 9'($urandom);
      checkOutput("held x_out", 32'(x_out), 32'(e.x));
      checkOutput("held out_valid", 32'(out_valid), 32'd1);
      checkOutput("held in_ready", 32'(in_ready), 32'd0);
    end
    @(negedge clock);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clock);
    #1;
    out_ready = 1'b0;
    checkOutput("out_valid after accept", 32'(out_valid), 32'd0);
    checkOutput("in_ready after accept", 32'(in_ready), 32'd1);
  endtask

  initial begin
    logic [8:0]  ry;
    logic [11:0] rx;
    int          rlat;

    #12;
    checkOutput("reset out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset in_ready", 32'(in_ready), 32'd1);
    checkOutput("reset x_out", 32'(x_out), 32'd0);
    @(negedge clock);
    resetn = 1'b1;

    applyStimulus(9'h000, 12'h000, 1); collectResult(0);
    applyStimulus(9'h080, 12'h0A8, 5); collectResult(0);
    applyStimulus(9'h180, 12'hF58, 5); collectResult(0);
    applyStimulus(9'h0E0, 12'h1A8, 6); collectResult(0);
    applyStimulus(9'h0FF, 12'h300, 4); collectResult(0);
    applyStimulus(9'h100, 12'hD00, 1); collectResult(0);
    applyStimulus(9'h080, 12'h0A8, 5); collectResult(10);

    // Abort in the ACC phase: the pending scoreboard entry is dropped
    applyStimulus(9'h080, 12'h0A8, 5);
    @(posedge clock);
    @(negedge clock);
    resetn = 1'b0;
    #1;
    checkOutput("abort out_valid", 32'(out_valid), 32'd0);
    checkOutput("abort x_out", 32'(x_out), 32'd0);
    checkOutput("abort in_ready", 32'(in_ready), 32'd1);
    void'(sb.pop_front());
    @(negedge clock);
    resetn = 1'b1;
    applyStimulus(9'h080, 12'h0A8, 5); collectResult(0);

    for (int n = 0; n < 20; n++) begin
      ry = 9'($urandom);
      model(ry, rx, rlat);
      applyStimulus(ry, rx, rlat);
      collectResult(int'($urandom_range(0, 3)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
